// File: rtl/lvds_align_pkg.sv
// Shared constants, port FSM state type and lane helpers for the LVDS word aligner.
package lvds_align_pkg;

    localparam logic [6:0] C_CLK_PATTERN = 7'b1100011;
    localparam int         C_LANE_W      = 7;
    localparam int         C_DATA_LANES  = 4;
    localparam int         C_PORT_W      = (C_DATA_LANES + 1) * C_LANE_W;
    localparam int         C_WORD_W      = C_DATA_LANES * C_LANE_W;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } port_state_t;

    typedef logic [C_LANE_W-1:0] lane_t;

    // Picks window[13-s -: 7] out of {prev, cur}; bit 13 is the earliest received bit.
    function automatic lane_t align_lane(input lane_t prev, input lane_t cur, input logic [2:0] s);
        logic [2*C_LANE_W-1:0] window;
        window = {prev, cur} << s;
        return window[2*C_LANE_W-1 -: C_LANE_W];
    endfunction

    function automatic logic [2:0] next_offset(input logic [2:0] s);
        return (s == 3'd6) ? 3'd0 : s + 3'd1;
    endfunction

    // Bit 4t+k carries lane k, bit (6-t): earliest bits land lowest, DE/VS/HS at 2/6/10.
    function automatic logic [C_WORD_W-1:0] pack_word(input logic [C_DATA_LANES-1:0][C_LANE_W-1:0] al);
        logic [C_WORD_W-1:0] w;
        w = '0;
        for (int t = 0; t < C_LANE_W; t++) begin
            for (int k = 0; k < C_DATA_LANES; k++) begin
                w[C_DATA_LANES*t + k] = al[k][C_LANE_W-1-t];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lvds_align_port.sv
// One LVDS port: lane history, rotator, lock FSM with hysteresis, and output packing.
module lvds_align_port
    import lvds_align_pkg::*;
#(
    parameter int C_LOCK_CNT = 16,
    parameter int C_ERR_MAX  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [C_PORT_W-1:0] lane_data,
    input  logic                valid,
    output logic [C_WORD_W-1:0] word,
    output logic                locked,
    output logic [2:0]          offset
);

    localparam int C_LANES    = C_DATA_LANES + 1;
    localparam int C_CLK_LANE = C_DATA_LANES;

    logic [C_LANES-1:0][C_LANE_W-1:0] cur;
    logic [C_LANES-1:0][C_LANE_W-1:0] prev_q;
    logic [C_LANES-1:0][C_LANE_W-1:0] aligned;

    port_state_t         state, state_nxt;
    logic [7:0]          cnt, cnt_nxt;
    logic [7:0]          err, err_nxt;
    logic [2:0]          offset_nxt;
    logic                primed, primed_nxt;
    logic                match;
    logic [C_WORD_W-1:0] word_nxt;

    assign cur    = lane_data;
    assign locked = (state == LOCKED);

    always_comb begin
        for (int k = 0; k < C_LANES; k++) begin
            aligned[k] = align_lane(prev_q[k], cur[k], offset);
        end
    end

    assign match = (aligned[C_CLK_LANE] == C_CLK_PATTERN);

    // Next state is evaluated as if VALID_I were high; the register only loads on valid words.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt  = state;
        cnt_nxt    = cnt;
        err_nxt    = err;
        offset_nxt = offset;
        primed_nxt = 1'b1;
        if (primed) begin
            case (state)
                SEARCH: begin
                    if (match) begin
                        state_nxt = CHECK;
                        cnt_nxt   = 8'd1;
                    end else begin
                        offset_nxt = next_offset(offset);
                    end
                end
                CHECK: begin
                    if (match) begin
                        cnt_nxt = cnt + 8'd1;
                        if (cnt + 8'd1 == 8'(C_LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            err_nxt   = 8'd0;
                        end
                    end else begin
                        state_nxt  = SEARCH;
                        cnt_nxt    = 8'd0;
                        offset_nxt = next_offset(offset);
                    end
                end
                LOCKED: begin
                    if (match) begin
                        err_nxt = 8'd0;
                    end else if (err + 8'd1 == 8'(C_ERR_MAX)) begin
                        state_nxt  = SEARCH;
                        err_nxt    = 8'd0;
                        cnt_nxt    = 8'd0;
                        offset_nxt = next_offset(offset);
                    end else begin
                        err_nxt = err + 8'd1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                end
            endcase
        end
    end

    // Gate on the state the word is emitted with, so LOCKED_O = 0 always pairs with a zero word.
    assign word_nxt = (state_nxt == LOCKED) ? pack_word(aligned[C_DATA_LANES-1:0]) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the lane history is cleared too; it is small and a known window keeps re-prime deterministic.
            prev_q <= '0;
            state  <= SEARCH;
            cnt    <= 8'd0;
            err    <= 8'd0;
            offset <= 3'd0;
            primed <= 1'b0;
            word   <= '0;
        end else if (valid) begin
            prev_q <= cur;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            err    <= err_nxt;
            offset <= offset_nxt;
            primed <= primed_nxt;
            word   <= word_nxt;
        end
    end

endmodule

// File: rtl/lvds_word_align.sv
// Per-port LVDS word alignment: one aligner per port, shared valid delay and lock summary.
module lvds_word_align
    import lvds_align_pkg::*;
#(
    parameter int C_PORT_NUM = 4,
    parameter int C_LOCK_CNT = 16,
    parameter int C_ERR_MAX  = 4
) (
    input  logic                           CLK_I,
    input  logic                           RSTN_I,
    input  logic [C_PORT_W*C_PORT_NUM-1:0] LANE_DATA_I,
    input  logic                           VALID_I,
    output logic [C_WORD_W*C_PORT_NUM-1:0] LVDS_DATA_O,
    output logic                           VALID_O,
    output logic [C_PORT_NUM-1:0]          LOCKED_O,
    output logic                           ALL_LOCKED_O,
    output logic [3*C_PORT_NUM-1:0]        OFFSET_O
);

    for (genvar p = 0; p < C_PORT_NUM; p++) begin : g_port
        lvds_align_port #(
            .C_LOCK_CNT (C_LOCK_CNT),
            .C_ERR_MAX  (C_ERR_MAX)
        ) u_port (
            .clk       (CLK_I),
            .rst_n     (RSTN_I),
            .lane_data (LANE_DATA_I[p*C_PORT_W +: C_PORT_W]),
            .valid     (VALID_I),
            .word      (LVDS_DATA_O[p*C_WORD_W +: C_WORD_W]),
            .locked    (LOCKED_O[p]),
            .offset    (OFFSET_O[3*p +: 3])
        );
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            VALID_O <= 1'b0;
        end else begin
            VALID_O <= VALID_I;
        end
    end

    assign ALL_LOCKED_O = &LOCKED_O;

endmodule
